// File: rtl/vend_ctrl_core.sv
// vend_ctrl_core: vending sales controller (row/column select, coin credit, pay, dispense, refund).
// Define VEND_CHANGE_EN to dispense on overpayment and return the change; otherwise exact pay only.
module vend_ctrl_core #(
   parameter int NUM_ROWS    = 4,
   parameter int NUM_COLS    = 4,
   parameter int KEY_W       = 2,
   parameter int VAL_W       = 10,
   parameter int MAX_CREDIT  = 200,
   parameter int ID_TIMEOUT  = 500,
   parameter int PAY_TIMEOUT = 2000,
   parameter int HOLD_CYC    = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_strobe,
   input  logic [KEY_W-1:0] key_idx,
   input  logic             cancel,
   input  logic             got_coin,
   input  logic [2:0]       coin,
   input  logic             prod_valid,
   input  logic [VAL_W-1:0] price_in,
   output logic [KEY_W-1:0] sel_row,
   output logic [KEY_W-1:0] sel_col,
   output logic [VAL_W-1:0] credit,
   output logic [VAL_W-1:0] change_val,
   output logic             release_product,
   output logic             back_money,
   output logic             coin_reject,
   output logic [2:0]       state
);
   localparam int M1 = ID_TIMEOUT > PAY_TIMEOUT ? ID_TIMEOUT : PAY_TIMEOUT;
   localparam int TW = $clog2(M1 > HOLD_CYC ? M1 : HOLD_CYC) + 1;
   localparam logic [2:0] S_IDLE = 3'd0, S_SEL_COL = 3'd1, S_CHECK = 3'd2,
                          S_PAY = 3'd3, S_DISPENSE = 3'd4, S_REFUND = 3'd5;

   logic [2:0]       state_nxt;
   logic [TW-1:0]    timer, hold;
   logic [VAL_W-1:0] val, disp_chg;
   logic [VAL_W:0]   sum;
   logic             row_ok, col_ok, t_id, t_pay, hold_done, has_credit;
   logic             suff, over, disp_back, acc, pay_exit;

   always_comb begin
      val = coin == 3'd1 ? VAL_W'(1) : coin == 3'd2 ? VAL_W'(2) : coin == 3'd3 ? VAL_W'(5) :
            coin == 3'd4 ? VAL_W'(10) : coin == 3'd5 ? VAL_W'(20) : '0;
      sum = {1'b0, credit} + {1'b0, val};
      row_ok = key_strobe && int'(key_idx) < NUM_ROWS;
      col_ok = key_strobe && int'(key_idx) < NUM_COLS;
      t_id = timer == TW'(ID_TIMEOUT - 1);
      t_pay = timer == TW'(PAY_TIMEOUT - 1);
      hold_done = hold == TW'(HOLD_CYC - 1);
      has_credit = credit != '0;
      pay_exit = state == S_PAY && state_nxt != S_PAY;
      // Coins only land before dispense/refund, and never in the cycle PAY resolves
      acc = got_coin && val != '0 && !state[2] && !pay_exit && sum <= (VAL_W + 1)'(MAX_CREDIT);
   end

`ifdef VEND_CHANGE_EN
   assign suff      = credit >= price_in;
   assign over      = 1'b0;
   assign disp_chg  = credit - price_in;
   assign disp_back = credit != price_in;
`else
   assign suff      = credit == price_in;
   assign over      = credit > price_in;
   assign disp_chg  = '0;
   assign disp_back = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= S_IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     state_nxt = row_ok ? S_SEL_COL : (cancel && has_credit) ? S_REFUND : S_IDLE;
         S_SEL_COL:  state_nxt = col_ok ? S_CHECK : (cancel || t_id) ? (has_credit ? S_REFUND : S_IDLE) : S_SEL_COL;
         S_CHECK:    state_nxt = prod_valid ? S_PAY : has_credit ? S_REFUND : S_IDLE;
         S_PAY:      state_nxt = suff ? S_DISPENSE : over ? S_REFUND :
                                 (cancel || t_pay) ? (has_credit ? S_REFUND : S_IDLE) : S_PAY;
         S_DISPENSE,
         S_REFUND:   state_nxt = hold_done ? S_IDLE : state;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         timer <= '0;
         hold  <= '0;
      end else begin
         timer <= (state_nxt != state || (state == S_PAY && acc)) ? '0 :
                  (state == S_SEL_COL || state == S_PAY) ? timer + 1'b1 : timer;
         hold  <= state_nxt != state ? '0 : state[2] ? hold + 1'b1 : hold;
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sel_row         <= '0;
         sel_col         <= '0;
         credit          <= '0;
         change_val      <= '0;
         release_product <= 1'b0;
         back_money      <= 1'b0;
         coin_reject     <= 1'b0;
      end else begin
         coin_reject <= got_coin && !acc;
         if (state[2] && hold_done) begin
            sel_row         <= '0;
            sel_col         <= '0;
            credit          <= '0;
            change_val      <= '0;
            release_product <= 1'b0;
            back_money      <= 1'b0;
         end else begin
            if (acc) credit <= sum[VAL_W-1:0];
            if (state == S_IDLE && row_ok) sel_row <= key_idx;
            if (state == S_SEL_COL && col_ok) sel_col <= key_idx;
            if (state == S_PAY && suff) begin
               change_val      <= disp_chg;
               release_product <= 1'b1;
               back_money      <= disp_back;
            end else if (state_nxt == S_REFUND && state != S_REFUND) begin
               change_val <= acc ? sum[VAL_W-1:0] : credit;
               back_money <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_vend_ctrl_core.sv
// tb_vend_ctrl_core: directed self-checking bench for vend_ctrl_core, both change modes.
module tb_vend_ctrl_core;
   localparam int HOLD = 5, IDT = 20, PAYT = 40;
   logic       clk = 0, rst = 0, key_strobe = 0, cancel = 0, got_coin = 0, prod_valid = 0;
   logic [1:0] key_idx = 0;
   logic [2:0] coin = 0;
   logic [9:0] price_in = 0;
   logic [1:0] sel_row, sel_col;
   logic [9:0] credit, change_val;
   logic       release_product, back_money, coin_reject;
   logic [2:0] state;
   int         n_chk = 0, n_fail = 0;

   vend_ctrl_core #(.NUM_ROWS(3), .NUM_COLS(3), .KEY_W(2), .VAL_W(10), .MAX_CREDIT(200),
                    .ID_TIMEOUT(IDT), .PAY_TIMEOUT(PAYT), .HOLD_CYC(HOLD)) dut (
      .clk(clk), .rst(rst), .key_strobe(key_strobe), .key_idx(key_idx), .cancel(cancel),
      .got_coin(got_coin), .coin(coin), .prod_valid(prod_valid), .price_in(price_in),
      .sel_row(sel_row), .sel_col(sel_col), .credit(credit), .change_val(change_val),
      .release_product(release_product), .back_money(back_money), .coin_reject(coin_reject),
      .state(state));

   always #5 clk = ~clk;

   task step; @(posedge clk); #1; endtask
   task press(input logic [1:0] k); key_idx = k; key_strobe = 1; step(); key_strobe = 0; endtask
   task drop(input logic [2:0] c); coin = c; got_coin = 1; step(); got_coin = 0; endtask
   task abort; cancel = 1; step(); cancel = 0; endtask
   task wait_idle(output int nb, output int nr);
      nb = 0; nr = 0;
      for (int i = 0; i < 60 && state != 3'd0; i++) begin
         nb += int'(back_money); nr += int'(release_product); step();
      end
   endtask

   task test_reset;
      step(); step(); rst = 1; step();
      n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
      n_chk++; if (credit !== 10'd0) begin n_fail++; $display("FAIL reset_credit: got %0d want 0", credit); end
      n_chk++; if (change_val !== 10'd0) begin n_fail++; $display("FAIL reset_change: got %0d want 0", change_val); end
      n_chk++; if ({sel_row, sel_col, release_product, back_money, coin_reject} !== 7'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0", {sel_row, sel_col, release_product, back_money, coin_reject}); end
   endtask

   task test_sale;
      int nb, nr;
      drop(4); drop(4);
      n_chk++; if (credit !== 10'd20) begin n_fail++; $display("FAIL sale_credit: got %0d want 20", credit); end
      price_in = 15; prod_valid = 1;
      press(1);
      n_chk++; if (state !== 3'd1 || sel_row !== 2'd1) begin n_fail++; $display("FAIL sale_row: got state %0d row %0d want 1 1", state, sel_row); end
      press(2);
      n_chk++; if (state !== 3'd2 || sel_col !== 2'd2) begin n_fail++; $display("FAIL sale_col: got state %0d col %0d want 2 2", state, sel_col); end
      step();
      n_chk++; if (state !== 3'd3) begin n_fail++; $display("FAIL sale_pay: got %0d want 3", state); end
      step();
`ifdef VEND_CHANGE_EN
      n_chk++; if (state !== 3'd4 || change_val !== 10'd5 || release_product !== 1'b1 || back_money !== 1'b1) begin n_fail++; $display("FAIL sale_disp: got st %0d chg %0d rel %b back %b want 4 5 1 1", state, change_val, release_product, back_money); end
      wait_idle(nb, nr);
      n_chk++; if (nr !== HOLD || nb !== HOLD) begin n_fail++; $display("FAIL sale_hold: got rel %0d back %0d want %0d %0d", nr, nb, HOLD, HOLD); end
`else
      n_chk++; if (state !== 3'd5 || change_val !== 10'd20 || release_product !== 1'b0 || back_money !== 1'b1) begin n_fail++; $display("FAIL sale_refund: got st %0d chg %0d rel %b back %b want 5 20 0 1", state, change_val, release_product, back_money); end
      wait_idle(nb, nr);
      n_chk++; if (nr !== 0 || nb !== HOLD) begin n_fail++; $display("FAIL sale_hold: got rel %0d back %0d want 0 %0d", nr, nb, HOLD); end
`endif
      n_chk++; if (state !== 3'd0 || credit !== 10'd0 || sel_row !== 2'd0 || change_val !== 10'd0) begin n_fail++; $display("FAIL sale_end: got st %0d cr %0d row %0d chg %0d want 0 0 0 0", state, credit, sel_row, change_val); end
   endtask

   task test_saturation;
      int nb, nr;
      for (int i = 0; i < 9; i++) drop(5);
      drop(4); drop(3);
      n_chk++; if (credit !== 10'd195) begin n_fail++; $display("FAIL sat_195: got %0d want 195", credit); end
      drop(5);
      n_chk++; if (coin_reject !== 1'b1 || credit !== 10'd195) begin n_fail++; $display("FAIL sat_reject: got rej %b cr %0d want 1 195", coin_reject, credit); end
      step();
      n_chk++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL sat_pulse: got %b want 0", coin_reject); end
      drop(3);
      n_chk++; if (coin_reject !== 1'b0 || credit !== 10'd200) begin n_fail++; $display("FAIL sat_200: got rej %b cr %0d want 0 200", coin_reject, credit); end
      drop(0);
      n_chk++; if (coin_reject !== 1'b1 || credit !== 10'd200) begin n_fail++; $display("FAIL sat_code0: got rej %b cr %0d want 1 200", coin_reject, credit); end
      abort();
      n_chk++; if (state !== 3'd5 || change_val !== 10'd200) begin n_fail++; $display("FAIL sat_cancel: got st %0d chg %0d want 5 200", state, change_val); end
      wait_idle(nb, nr);
      n_chk++; if (state !== 3'd0 || credit !== 10'd0 || nb !== HOLD) begin n_fail++; $display("FAIL sat_end: got st %0d cr %0d back %0d want 0 0 %0d", state, credit, nb, HOLD); end
   endtask

   task test_id_timeout;
      int n, nb, nr;
      press(1);
      n = 0;
      for (int i = 0; i < 100 && state == 3'd1; i++) begin n++; step(); end
      n_chk++; if (n !== IDT || state !== 3'd0 || back_money !== 1'b0) begin n_fail++; $display("FAIL idto_zero: got cyc %0d st %0d back %b want %0d 0 0", n, state, back_money, IDT); end
      drop(4); press(1);
      n = 0;
      for (int i = 0; i < 100 && state == 3'd1; i++) begin n++; step(); end
      n_chk++; if (n !== IDT || state !== 3'd5 || change_val !== 10'd10 || back_money !== 1'b1) begin n_fail++; $display("FAIL idto_refund: got cyc %0d st %0d chg %0d back %b want %0d 5 10 1", n, state, change_val, back_money, IDT); end
      wait_idle(nb, nr);
      n_chk++; if (state !== 3'd0 || credit !== 10'd0) begin n_fail++; $display("FAIL idto_end: got st %0d cr %0d want 0 0", state, credit); end
   endtask

   task test_invalid;
      int nb, nr;
      press(3);
      n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL inv_row: got %0d want 0", state); end
      key_idx = 0; key_strobe = 1; coin = 3; got_coin = 1; step(); key_strobe = 0; got_coin = 0;
      n_chk++; if (state !== 3'd1 || credit !== 10'd5) begin n_fail++; $display("FAIL inv_both: got st %0d cr %0d want 1 5", state, credit); end
      press(3);
      n_chk++; if (state !== 3'd1) begin n_fail++; $display("FAIL inv_col: got %0d want 1", state); end
      prod_valid = 0;
      press(1);
      n_chk++; if (state !== 3'd2) begin n_fail++; $display("FAIL inv_check: got %0d want 2", state); end
      step();
      n_chk++; if (state !== 3'd5 || change_val !== 10'd5) begin n_fail++; $display("FAIL inv_refund: got st %0d chg %0d want 5 5", state, change_val); end
      wait_idle(nb, nr);
      n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL inv_end: got %0d want 0", state); end
   endtask

   task test_pay_cancel;
      int nb, nr;
      price_in = 30; prod_valid = 1;
      drop(4); press(1); press(1); step();
      n_chk++; if (state !== 3'd3) begin n_fail++; $display("FAIL pc_pay: got %0d want 3", state); end
      drop(4);
      n_chk++; if (state !== 3'd3 || credit !== 10'd20) begin n_fail++; $display("FAIL pc_coin: got st %0d cr %0d want 3 20", state, credit); end
      abort();
      n_chk++; if (state !== 3'd5 || change_val !== 10'd20) begin n_fail++; $display("FAIL pc_refund: got st %0d chg %0d want 5 20", state, change_val); end
      drop(4);
      n_chk++; if (coin_reject !== 1'b1 || credit !== 10'd20) begin n_fail++; $display("FAIL pc_reject: got rej %b cr %0d want 1 20", coin_reject, credit); end
      wait_idle(nb, nr);
      n_chk++; if (state !== 3'd0 || credit !== 10'd0) begin n_fail++; $display("FAIL pc_end: got st %0d cr %0d want 0 0", state, credit); end
   endtask

   task test_back_to_back;
      int nb, nr;
      price_in = 5; prod_valid = 1;
      drop(3); press(0); press(0); step();
      abort();
      n_chk++; if (state !== 3'd4 || release_product !== 1'b1 || back_money !== 1'b0) begin n_fail++; $display("FAIL prio_disp: got st %0d rel %b back %b want 4 1 0", state, release_product, back_money); end
      wait_idle(nb, nr);
      n_chk++; if (state !== 3'd0 || nr !== HOLD) begin n_fail++; $display("FAIL prio_end: got st %0d rel %0d want 0 %0d", state, nr, HOLD); end
   endtask

   task test_reset_mid;
      price_in = 15; prod_valid = 1;
      drop(4); drop(4); press(1); press(2); step(); step(); step();
`ifdef VEND_CHANGE_EN
      n_chk++; if (state !== 3'd4 || release_product !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got st %0d rel %b want 4 1", state, release_product); end
`else
      n_chk++; if (state !== 3'd5 || back_money !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got st %0d back %b want 5 1", state, back_money); end
`endif
      #2 rst = 0;
      #1;
      n_chk++; if (state !== 3'd0 || credit !== 10'd0 || change_val !== 10'd0) begin n_fail++; $display("FAIL rm_async: got st %0d cr %0d chg %0d want 0 0 0", state, credit, change_val); end
      n_chk++; if ({sel_row, sel_col, release_product, back_money, coin_reject} !== 7'd0) begin n_fail++; $display("FAIL rm_flags: got %b want 0", {sel_row, sel_col, release_product, back_money, coin_reject}); end
      #2 rst = 1;
      step();
      n_chk++; if (state !== 3'd0 || back_money !== 1'b0) begin n_fail++; $display("FAIL rm_after: got st %0d back %b want 0 0", state, back_money); end
   endtask

   initial begin
      test_reset();
      test_sale();
      test_saturation();
      test_id_timeout();
      test_invalid();
      test_pay_cancel();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vend_ctrl_core.md
# vend_ctrl_core

Parametrised vending-machine sales controller. It sequences product selection (row key, then column key), coin crediting with value decode and saturation, price comparison, change computation, refunds, and timeouts. It replaces the fixed two-key, fixed-width sales machine in the vending top level. The external price/ID table and the display driver stay outside; they consume `sel_row`, `sel_col` and `state`.

## Interface
Parameters:
- `NUM_ROWS`, 4: valid row indices 0..NUM_ROWS-1.
- `NUM_COLS`, 4: valid column indices 0..NUM_COLS-1.
- `KEY_W`, 2: key index width; must satisfy 2^KEY_W ≥ max(NUM_ROWS, NUM_COLS).
- `VAL_W`, 10: credit/price/change width, in units of 5 cents.
- `MAX_CREDIT`, 200: credit ceiling; must be < 2^VAL_W.
- `ID_TIMEOUT`, 500: cycles allowed between row and column keys.
- `PAY_TIMEOUT`, 2000: cycles of coin inactivity allowed in PAY.
- `HOLD_CYC`, 100: cycles `release_product`/`back_money` stay asserted.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `key_strobe`  in  1  one-cycle key press pulse.
- `key_idx`  in  KEY_W  key index, valid with `key_strobe`.
- `cancel`  in  1  one-cycle abort pulse.
- `got_coin`  in  1  one-cycle coin pulse.
- `coin`  in  3  coin code, valid with `got_coin`.
- `prod_valid`  in  1  external table: the (`sel_row`,`sel_col`) product exists.
- `price_in`  in  VAL_W  external table: price of (`sel_row`,`sel_col`).
- `sel_row`  out  KEY_W  latched row.
- `sel_col`  out  KEY_W  latched column.
- `credit`  out  VAL_W  current accumulated credit.
- `change_val`  out  VAL_W  amount being returned; valid while `back_money`=1.
- `release_product`  out  1  dispense level.
- `back_money`  out  1  coin-return level.
- `coin_reject`  out  1  one-cycle pulse: the coin was not credited.
- `state`  out  3  IDLE=0, SEL_COL=1, CHECK=2, PAY=3, DISPENSE=4, REFUND=5.

## Operation
- Coin decode, in units of 5 cents: 1→1, 2→2, 3→5, 4→10, 5→20. Codes 0, 6 and 7 are rejected.
- A coin is credited in IDLE, SEL_COL, CHECK or PAY when `credit + value ≤ MAX_CREDIT`. Otherwise it is rejected and `credit` is unchanged; credit never wraps.
- Coins in DISPENSE or REFUND are always rejected.
- In the cycle PAY exits to DISPENSE or REFUND, a coin is rejected.
- IDLE: `key_strobe` with `key_idx < NUM_ROWS` latches `sel_row` and moves to SEL_COL. Out-of-range keys are ignored. `cancel` with `credit > 0` moves to REFUND.
- SEL_COL: `key_strobe` with `key_idx < NUM_COLS` latches `sel_col` and moves to CHECK. `cancel`, or a timer expiry at ID_TIMEOUT, moves to REFUND if `credit > 0`, else to IDLE.
- CHECK: lasts exactly one cycle. `prod_valid = 0` moves to REFUND if `credit > 0`, else to IDLE. `prod_valid = 1` moves to PAY.
- PAY: the sufficiency test `credit ≥ price_in` uses the registered `credit`.
  - Test true: move to DISPENSE and latch `change_val = credit − price_in`.
  - `cancel`, or a timer expiry at PAY_TIMEOUT: move to REFUND if `credit > 0`, else to IDLE.
  - If `cancel` and sufficiency occur in the same cycle, sufficiency wins.
- DISPENSE: `release_product` = 1 for HOLD_CYC cycles. `back_money` = 1 for the same cycles when `change_val > 0`. Then `credit`, `change_val`, `sel_row` and `sel_col` clear and the state returns to IDLE.
- REFUND: latch `change_val = credit`. `back_money` = 1 for HOLD_CYC cycles, then everything clears and the state returns to IDLE.
- Timer: clears on every state entry and on every credited coin in PAY. Within a state it counts only in SEL_COL and PAY. Its width is $clog2 of the largest of the three cycle parameters, plus 1.

## Timing
- Reset values: state = IDLE; `sel_row`, `sel_col`, `credit` and `change_val` = 0; `release_product`, `back_money` and `coin_reject` = 0. Reset mid-sale aborts immediately, with no refund pulse.
- All outputs are registered.
- Key or coin to state/credit update: 1 cycle. `coin_reject` is asserted in the cycle after `got_coin`.
- PAY with sufficient credit: `release_product` rises 1 cycle after the sufficiency cycle and stays high exactly HOLD_CYC cycles. IDLE follows the next cycle.
- `price_in`/`prod_valid` must settle within one cycle of a `sel_row`/`sel_col` change; CHECK gives that margin.
- Simultaneous `key_strobe` and `got_coin`: both are processed in the same cycle.

## Configuration
- `VEND_CHANGE_EN` defined: overpayment dispenses the product and returns the change, as described above.
- `VEND_CHANGE_EN` undefined (exact-pay mode):
  - PAY moves to DISPENSE only when `credit == price_in`.
  - `credit > price_in` moves to REFUND and returns the full credit.
  - In DISPENSE, `change_val` is 0 and `back_money` stays 0.

## Test plan
- Reset, then coins 4,4 (credit 20), keys 1 then 2, `price_in` = 15, `prod_valid` = 1 → PAY → DISPENSE. `release_product` and `back_money` are high for HOLD_CYC cycles with `change_val` = 5, then IDLE with `credit` = 0. Without the macro: REFUND with `change_val` = 20 and `release_product` = 0.
- Credit 195, then coin 5 (value 20) → `coin_reject` pulse, `credit` stays 195. Then coin 3 → `credit` = 200.
- Key row 1, then no column key for ID_TIMEOUT cycles with credit 0 → IDLE with no `back_money`. Repeat with credit 10 → REFUND with `change_val` = 10.
- Column key with `prod_valid` = 0 and credit 5 → CHECK → REFUND. `key_idx` ≥ NUM_ROWS in IDLE is ignored, and the state stays 0.
- In PAY with credit 10 and price 30: coin 4 in cycle N, `cancel` in N+1 → REFUND with `change_val` = 20. A coin during REFUND → `coin_reject`, credit unchanged.
- `rst` asserted during DISPENSE → all outputs drop to their reset values asynchronously, and `state` = 0.
